// File: rtl/vcache_profiler_pkg.sv
// vcache_profiler_pkg: shared types and constants for the vcache profiler stat generator.
package vcache_profiler_pkg;

    localparam int global_ctr_width_gp = 32;
    localparam logic [27:0] print_stat_addr_gp = 28'h0F0_0000;

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_e;

endpackage

// File: rtl/vcache_print_stat_fifo.sv
// vcache_print_stat_fifo: synchronous FIFO with combinational head from registered storage and a count output.
module vcache_print_stat_fifo #(
    parameter int width_p = 32,
    parameter int els_p = 4,
    localparam int pw_lp = $clog2(els_p),
    localparam int cw_lp = pw_lp + 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enq_i,
    input  logic               deq_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] head_o,
    output logic [cw_lp-1:0]   count_o,
    output logic               full_o,
    output logic               empty_o
);

    logic [width_p-1:0] mem_q [els_p];
    logic [pw_lp-1:0] rptr_q, wptr_q;
    logic [cw_lp-1:0] count_q;
    logic enq_ok, deq_ok;

    assign full_o  = count_q == cw_lp'(els_p);
    assign empty_o = count_q == '0;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign enq_ok  = enq_i & (~full_o | deq_i);
    assign deq_ok  = deq_i & ~empty_o;
    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i)
        if (enq_ok) mem_q[wptr_q] <= data_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq_ok) wptr_q <= wptr_q + 1'b1;
            if (deq_ok) rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + cw_lp'(enq_ok) - cw_lp'(deq_ok);
        end
    end

endmodule

// File: rtl/vcache_print_stat_gen.sv
// vcache_print_stat_gen: snoops print-stat stores, replays them as rate-limited pulses, owns the global counter.
// Define VCACHE_PRINT_STAT_GEN_CTR_SATURATE_EN to make the global counter saturate instead of wrap.
module vcache_print_stat_gen
    import vcache_profiler_pkg::*;
#(
    parameter int data_width_p = 32,
    parameter int addr_width_p = 28,
    parameter logic [addr_width_p-1:0] print_stat_addr_p = print_stat_addr_gp,
    parameter int els_p = 4,
    parameter int gap_p = 8,
    localparam int cw_lp = $clog2(els_p) + 1,
    localparam int gw_lp = $clog2(gap_p + 1)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    input  logic                           ready_i,
    input  logic                           w_i,
    input  logic [addr_width_p-1:0]        addr_i,
    input  logic [data_width_p-1:0]        data_i,
    output logic [global_ctr_width_gp-1:0] global_ctr_o,
    output logic                           print_stat_v_o,
    output logic [data_width_p-1:0]        print_stat_tag_o,
    output logic [cw_lp-1:0]               pending_o,
    output logic                           drop_o
);

    state_e state_q, state_d;
    logic [gw_lp-1:0] gap_q, gap_d;
    logic [global_ctr_width_gp-1:0] ctr_q, ctr_d;
    logic [data_width_p-1:0] tag_q, head;
    logic v_q, drop_q, trig, deq, issue, full, empty;

    assign trig = v_i & ready_i & w_i & (addr_i == print_stat_addr_p);

    vcache_print_stat_fifo #(.width_p(data_width_p), .els_p(els_p)) fifo (
        .clk_i(clk_i), .reset_i(reset_i), .enq_i(trig), .deq_i(deq), .data_i(data_i),
        .head_o(head), .count_o(pending_o), .full_o(full), .empty_o(empty)
    );

    // The last gap cycle doubles as an idle cycle so pulses sit exactly gap_p+1 apart.
    assign issue   = (state_q == IDLE) | (state_q == GAP & gap_q == '0);
    assign deq     = issue & ~empty;
    assign state_d = deq ? EMIT : (state_q == EMIT | (state_q == GAP & gap_q != '0)) ? GAP : IDLE;
    assign gap_d   = state_q == EMIT ? gw_lp'(gap_p - 1) : gap_q != '0 ? gap_q - 1'b1 : gap_q;

`ifdef VCACHE_PRINT_STAT_GEN_CTR_SATURATE_EN
    assign ctr_d = ctr_q == '1 ? ctr_q : ctr_q + 1'b1;
`else
    assign ctr_d = ctr_q + 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            gap_q   <= '0;
            ctr_q   <= '0;
            v_q     <= 1'b0;
            tag_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            ctr_q   <= ctr_d;
            v_q     <= deq;
            if (deq) tag_q <= head;
            drop_q  <= drop_q | (trig & full & ~deq);
        end
    end

    assign global_ctr_o     = ctr_q;
    assign print_stat_v_o   = v_q;
    assign print_stat_tag_o = tag_q;
    assign drop_o           = drop_q;

endmodule

// File: tb/tb_vcache_print_stat_gen.sv
// tb_vcache_print_stat_gen: directed bench for the print-stat generator (default wrap build).
module tb_vcache_print_stat_gen;

    logic clk = 1'b0, reset = 1'b1, v = 1'b0, ready = 1'b0, w = 1'b0;
    logic [27:0] addr = '0;
    logic [31:0] data = '0;
    logic [31:0] ctr, tag;
    logic psv, drop;
    logic [2:0] pending;
    int errors = 0, checks = 0;

    localparam logic [27:0] trig_addr = 28'h0F0_0000;

    vcache_print_stat_gen dut (
        .clk_i(clk), .reset_i(reset), .v_i(v), .ready_i(ready), .w_i(w), .addr_i(addr),
        .data_i(data), .global_ctr_o(ctr), .print_stat_v_o(psv), .print_stat_tag_o(tag),
        .pending_o(pending), .drop_o(drop)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic vv, input logic rr, input logic ww, input logic [27:0] aa, input logic [31:0] dd);
        v = vv; ready = rr; w = ww; addr = aa; data = dd;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_in();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_pulse(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (psv) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (tag !== 32'h0) begin errors++; $display("FAIL reset_tag got %h want 0", tag); end
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", drop); end
        for (int i = 0; i < 100; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (ctr !== 32'(i)) begin errors++; $display("FAIL ctr_count got %0d want %0d", ctr, i); end
            checks++; if (psv !== 1'b0 || pending !== 3'd0) begin errors++; $display("FAIL idle_quiet got v=%b pend=%0d want 0/0", psv, pending); end
        end
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b1, 1'b1, 1'b1, trig_addr, 32'hA5);
        @(negedge clk);
        idle_in();
        checks++; if (psv !== 1'b0 || pending !== 3'd1) begin errors++; $display("FAIL single_enq got v=%b pend=%0d want 0/1", psv, pending); end
        @(negedge clk);
        checks++; if (psv !== 1'b1 || tag !== 32'hA5) begin errors++; $display("FAIL single_pulse got v=%b tag=%h want 1/a5", psv, tag); end
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL single_pend got %0d want 0", pending); end
        @(negedge clk);
        checks++; if (psv !== 1'b0 || tag !== 32'hA5) begin errors++; $display("FAIL single_hold got v=%b tag=%h want 0/a5", psv, tag); end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        drive(1'b1, 1'b1, 1'b1, trig_addr, 32'd1);
        @(negedge clk);
        data = 32'd2;
        @(negedge clk);
        checks++; if (psv !== 1'b1 || tag !== 32'd1) begin errors++; $display("FAIL b2b_p1 got v=%b tag=%0d want 1/1", psv, tag); end
        data = 32'd3;
        @(negedge clk);
        idle_in();
        wait_pulse(20, n);
        checks++; if (n !== 8 || tag !== 32'd2) begin errors++; $display("FAIL b2b_p2 got dist=%0d tag=%0d want 8/2", n, tag); end
        wait_pulse(20, n);
        checks++; if (n !== 9 || tag !== 32'd3) begin errors++; $display("FAIL b2b_p3 got dist=%0d tag=%0d want 9/3", n, tag); end
        checks++; if (drop !== 1'b0 || pending !== 3'd0) begin errors++; $display("FAIL b2b_end got drop=%b pend=%0d want 0/0", drop, pending); end
    endtask

    task automatic test_overflow();
        int n;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b1, trig_addr, 32'(10 + i));
            @(negedge clk);
            if (i == 1) begin
                checks++; if (psv !== 1'b1 || tag !== 32'd10) begin errors++; $display("FAIL ovf_p1 got v=%b tag=%0d want 1/10", psv, tag); end
            end
        end
        idle_in();
        checks++; if (drop !== 1'b1 || pending !== 3'd4) begin errors++; $display("FAIL ovf_drop got drop=%b pend=%0d want 1/4", drop, pending); end
        repeat (4) @(negedge clk);
        checks++; if (psv !== 1'b0) begin errors++; $display("FAIL ovf_gap got v=%b want 0", psv); end
        // Trigger lands on the dequeue edge while full: must be kept.
        drive(1'b1, 1'b1, 1'b1, trig_addr, 32'd16);
        @(negedge clk);
        idle_in();
        checks++; if (psv !== 1'b1 || tag !== 32'd11 || pending !== 3'd4) begin errors++; $display("FAIL ovf_p2 got v=%b tag=%0d pend=%0d want 1/11/4", psv, tag, pending); end
        for (int k = 0; k < 4; k++) begin
            wait_pulse(20, n);
            checks++; if (n !== 9 || tag !== (k == 3 ? 32'd16 : 32'(12 + k))) begin errors++; $display("FAIL ovf_order k=%0d got dist=%0d tag=%0d", k, n, tag); end
        end
        wait_pulse(20, n);
        checks++; if (n !== -1 || pending !== 3'd0) begin errors++; $display("FAIL ovf_tail got dist=%0d pend=%0d want -1/0", n, pending); end
    endtask

    task automatic test_ignore();
        int n;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: drive(1'b1, 1'b0, 1'b1, trig_addr, 32'h11);
                1: drive(1'b1, 1'b1, 1'b0, trig_addr, 32'h22);
                2: drive(1'b1, 1'b1, 1'b1, trig_addr + 28'd1, 32'h33);
                default: drive(1'b0, 1'b1, 1'b1, trig_addr, 32'h44);
            endcase
            @(negedge clk);
            idle_in();
            checks++; if (pending !== 3'd0) begin errors++; $display("FAIL ignore_enq k=%0d got pend=%0d want 0", k, pending); end
        end
        wait_pulse(12, n);
        checks++; if (n !== -1 || tag !== 32'h0) begin errors++; $display("FAIL ignore_pulse got dist=%0d tag=%h want -1/0", n, tag); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, trig_addr, 32'(i));
            @(negedge clk);
        end
        idle_in();
        checks++; if (pending !== 3'd2 || tag !== 32'd1) begin errors++; $display("FAIL mid_pre got pend=%0d tag=%0d want 2/1", pending, tag); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (psv !== 1'b0 || pending !== 3'd0 || ctr !== 32'd0) begin errors++; $display("FAIL mid_rst got v=%b pend=%0d ctr=%0d want 0/0/0", psv, pending, ctr); end
        @(negedge clk);
        checks++; if (psv !== 1'b0 || ctr !== 32'd1) begin errors++; $display("FAIL mid_after got v=%b ctr=%0d want 0/1", psv, ctr); end
        wait_pulse(12, n);
        checks++; if (n !== -1) begin errors++; $display("FAIL mid_quiet got dist=%0d want -1", n); end
        drive(1'b1, 1'b1, 1'b1, trig_addr, 32'h77);
        @(negedge clk);
        idle_in();
        checks++; if (psv !== 1'b0) begin errors++; $display("FAIL mid_lat1 got v=%b want 0", psv); end
        @(negedge clk);
        checks++; if (psv !== 1'b1 || tag !== 32'h77) begin errors++; $display("FAIL mid_lat2 got v=%b tag=%h want 1/77", psv, tag); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_ignore();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vcache_print_stat_gen.md
Name: vcache_print_stat_gen

Overview:
Upstream driver of the vcache profilers' stat inputs: global_ctr, print_stat_v and print_stat_tag.
- Snoops accepted remote stores on the host-to-vcache request path.
- Detects stores to the print-stat trigger address and queues their data words as tags.
- Replays each tag as a single-cycle print_stat pulse, rate-limited so every profiler can finish its file write.
- Owns the free-running global cycle counter shared by all vcache profilers.

Parameters:
- data_width_p, 32, width of snooped store data and of the emitted tag.
- addr_width_p, 28, width of the snooped request address.
- print_stat_addr_p, 28'h0F0_0000, word address that triggers a stat print.
- els_p, 4, tag FIFO depth; power of two, at least 2.
- gap_p, 8, minimum idle cycles between consecutive print_stat pulses; at least 1.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- v_i  in  1  snooped request valid.
- ready_i  in  1  snooped request accepted by the sink; a transfer occurs when v_i & ready_i.
- w_i  in  1  request is a store.
- addr_i  in  addr_width_p  request word address.
- data_i  in  data_width_p  store data, used as the tag.
- global_ctr_o  out  32  free-running cycle count.
- print_stat_v_o  out  1  one-cycle stat-print pulse.
- print_stat_tag_o  out  data_width_p  tag for the pulse; holds its last value otherwise.
- pending_o  out  log2(els_p)+1  number of tags currently queued.
- drop_o  out  1  sticky: a trigger was lost because the FIFO was full.

Behaviour:
Reset
- All outputs are 0. FIFO is empty. FSM is in IDLE.
- Reset asserted mid-operation discards all queued tags and any in-progress gap. There is no pulse on the reset cycle or the cycle after.

Global counter
- global_ctr_o is 0 in the first cycle after reset deasserts and increments by 1 every cycle after that.
- On reaching 32'hFFFF_FFFF it wraps to 0 (see Optional Feature).

Trigger
- trig = v_i & ready_i & w_i & (addr_i == print_stat_addr_p).
- Loads and stores to other addresses are ignored.
- Trigger data is enqueued into the FIFO on the same edge it is sampled.
- If the FIFO is full and no dequeue happens that cycle, the trigger is dropped and drop_o is set. drop_o clears only on reset.
- If the FIFO is full and a dequeue happens in the same cycle, the enqueue succeeds and nothing is dropped.

FSM
- IDLE: when the FIFO is non-empty, dequeue the head. At the next edge, register the tag, assert print_stat_v_o and go to EMIT.
  - Latency from the trigger edge to the pulse is 2 cycles when idle: the trigger is registered at edge N, the pulse is visible during cycle N+1.
- EMIT: print_stat_v_o is high for exactly one cycle. Load the gap counter with gap_p-1, then go to GAP.
- GAP: print_stat_v_o stays low and the counter decrements each cycle. When it reaches 0, go to IDLE. IDLE may dequeue in that same cycle.
- Pulse spacing is therefore at least gap_p+1 cycles edge to edge.
- print_stat_tag_o updates only when a pulse is emitted.

FIFO
- pending_o equals enqueues minus dequeues.
- A simultaneous enqueue and dequeue leaves pending_o unchanged.
- Pointers wrap modulo els_p.
- Tags are emitted in FIFO order.

Optional Feature:
Macro: VCACHE_PRINT_STAT_GEN_CTR_SATURATE_EN
- Defined: global_ctr_o saturates at 32'hFFFF_FFFF and stays there until reset.
- Undefined: global_ctr_o wraps to 0.

Decomposition:
- Shared package (vcache_profiler_pkg):
  - FSM state typedef {IDLE, EMIT, GAP}.
  - Constant global_ctr_width_gp = 32.
  - Default print-stat trigger address constant.
- Sub-module: vcache_print_stat_fifo, a parameterised synchronous FIFO with registered head and count output.
- The top level holds the trigger decode, the FSM, the gap counter and the global counter.

Test Plan:
- Reset release, no stimulus: global_ctr_o reads 0,1,2,…,99 over 100 cycles; print_stat_v_o stays 0; pending_o stays 0.
- Single store to 0x0F00000 with data 0xA5 at edge 10: print_stat_v_o high only in cycle 11 with tag 0xA5; pending_o returns to 0.
- Back-to-back triggers with tags 1,2,3 on consecutive cycles, gap_p=8: pulses with tags 1,2,3 exactly 9 cycles apart; drop_o stays 0.
- 6 triggers in 6 consecutive cycles with els_p=4: correct drop count against the dequeue timing, drop_o=1, surviving tags emitted in order.
- Triggers with ready_i=0, a load to the trigger address, and a store to 0x0F00001: no pulse and no enqueue.
- Reset asserted in GAP with 2 tags pending: after release pending_o=0, no pulse; a new trigger then pulses at 2-cycle latency. With the macro defined, force the counter to 32'hFFFF_FFFE: it reads FFFF_FFFF and holds there.
